fft_bitrev_buffer_rtl: RTL and testbench
========================================

Name: fft_bitrev_buffer_rtl

Overview:
- Input reorder stage directly upstream of the first-stage butterfly (fft_block_simplified_rtl / fft_block_rtl).
- Accepts complex samples in natural order over valid/ready and stores them in ping-pong banks.
- Emits each frame as N/2 butterfly operand pairs {first, second} in bit-reversed order, so stage 1 reads x[bitrev(2k)] and x[bitrev(2k)+N/2].
- One bank fills while the other drains, so input streams without gaps between frames.

Parameters:
- N_POINTS, 16, FFT length; power of two, >= 4.
- LOG2N, $clog2(N_POINTS), address width; derived, not overridden.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronised externally.
- in_valid  in  1  in_data valid.
- in_ready  out  1  buffer can accept a sample.
- in_data  in  32 (complex_t)  natural-order sample.
- out_valid  out  1  out_first/out_second valid.
- out_ready  in  1  downstream accepts the pair.
- out_first  out  32 (complex_t)  butterfly upper operand.
- out_second  out  32 (complex_t)  butterfly lower operand.
- out_pair_idx  out  LOG2N-1  pair index k, 0..N/2-1.
- out_frame_start  out  1  high with pair k=0.
- out_frame_last  out  1  high with pair k=N/2-1.

Behaviour:
- Reset (async, reset=0): all outputs 0, except in_ready=0 while reset is asserted. Both banks empty, wr_sel=0, rd_sel=0, counters 0. Bank contents are not cleared. in_ready rises on the first clk edge after deassertion.
- Storage: 2 banks x N_POINTS x complex_t. Per-bank full flag bank_full[1:0].
- Write side:
  - in_ready = !bank_full[wr_sel].
  - On in_valid && in_ready, write in_data to bank[wr_sel][wr_cnt], then wr_cnt++.
  - When wr_cnt == N-1 is written: set bank_full[wr_sel], toggle wr_sel, wr_cnt <= 0.
- Read FSM, states R_IDLE and R_DRAIN:
  - R_IDLE -> R_DRAIN when bank_full[rd_sel]; rd_cnt = 0.
  - In R_DRAIN, load the output register whenever !out_valid || out_ready. Load values: first = bank[rd_sel][bitrev(2*rd_cnt)], second = bank[rd_sel][bitrev(2*rd_cnt)+N/2], pair_idx = rd_cnt, frame flags accordingly. Then rd_cnt++.
  - After the load of rd_cnt == N/2-1: clear bank_full[rd_sel], toggle rd_sel. Go to R_DRAIN again (rd_cnt=0) if the other bank is already full in that cycle, else R_IDLE.
- Output register holds its value while out_valid && !out_ready; no pair is dropped or duplicated.
- out_valid drops after the last pair is accepted unless the next frame is already loading.
- Latency: the handshake of sample N-1 at edge t sets bank_full at t. out_valid is asserted at edge t+2 (R_IDLE -> R_DRAIN, then load).
- Back-to-back frames with out_ready=1: pairs are contiguous across the frame boundary.
- Simultaneous events: the write completing bank A and the read releasing bank B in the same cycle are both honoured. A bank being released is writable the next cycle, not the same cycle.
- Both banks full: in_ready=0 until the reader releases one.
- Arithmetic: pure data movement, bit-exact, no width change (except under the optional feature).

Optional Feature:
- FFT_BITREV_SCALE_EN defined: each Re/Im is arithmetically shifted right by 1 at write (floor, sign preserved), giving 1/2 pre-scaling against butterfly growth. Example: -3 -> -2, 0x7FFF -> 0x3FFF.
- Not defined: samples are stored unmodified.

Decomposition:
- fft_package gets:
  - FFT_N, FFT_LOG2N constants.
  - pair_idx_t typedef.
  - bitrev(addr, width) function.
  - existing word_t/complex_t.
- One sub-module, fft_pingpong_bank_rtl: dual-bank storage, one write port, two combinational read ports. Write/read FSMs stay in the top module.

Test Plan:
- N=16, x[i]={Re=i, Im=-i}, out_ready=1. Expected pairs:
  - k0: (x0, x8)
  - k1: (x4, x12)
  - k2: (x2, x10)
  - k7: (x7, x15)
  - frame_start with k0, frame_last with k7.
  - First out_valid exactly 2 cycles after sample 15 is accepted.
- Continuous input over 3 frames with out_ready=1: in_ready never drops; 24 pairs; no gap at the frame boundary.
- out_ready held 0 from k3 for 5 cycles: out_first=x6, out_second=x14 stable; resume yields k4=(x1,x9) with no loss.
- out_ready=0 permanently, 32+ samples offered: in_ready drops after sample 31 (both banks full). It rises one cycle after out_ready returns and frame 0 drains.
- reset pulled low mid-drain (k=3) and mid-fill: outputs 0 immediately (async). After release, a fresh frame produces k0=(x0,x8) with no stale data emitted.
- FFT_BITREV_SCALE_EN defined, x0={-3, 0x7FFF}, x8={5, -1}: k0 first={-2, 0x3FFF}, second={2, -1}.

Source files
------------

// File: rtl/fft_package.sv
// Shared FFT types, sizes and helpers for the input reorder stage.
// Purely declarative, no latency of its own.
// No flow control; consumed by the buffer and bank modules.
package fft_package;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = $clog2(FFT_N);

  typedef logic signed [15:0] word_t;

  typedef struct packed {
    word_t re;
    word_t im;
  } complex_t;

  typedef logic [FFT_LOG2N-2:0] pair_idx_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rd_state_e;

  // Reverse the low 'width' bits of addr; bits above width come back zero.
  function automatic logic [31:0] bitrev(input logic [31:0] addr, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        r[5'(i)] = addr[5'(width - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_buffer_rtl_bank.sv
// Dual-bank sample storage: one synchronous write port, two combinational reads.
// Write lands on the rising edge; reads are same-cycle from the selected bank.
// No flow control here; the owning module decides when writes are legal.
module fft_pingpong_bank_rtl
  import fft_package::*;
#(
  parameter int N_POINTS = FFT_N,
  localparam int AW = $clog2(N_POINTS)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic          wr_bank_i,
  input  logic [AW-1:0] wr_addr_i,
  input  complex_t      wr_data_i,
  input  logic          rd_bank_i,
  input  logic [AW-1:0] rd_addr_a_i,
  input  logic [AW-1:0] rd_addr_b_i,
  output complex_t      rd_data_a_o,
  output complex_t      rd_data_b_o
);

  // Contents are deliberately left unreset: full flags in the owner gate reads.
  complex_t mem_q [2][N_POINTS];

  // Single write port into whichever bank the writer currently owns.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
  end

  // Both butterfly operands of a pair come from the same bank in one cycle.
  assign rd_data_a_o = mem_q[rd_bank_i][rd_addr_a_i];
  assign rd_data_b_o = mem_q[rd_bank_i][rd_addr_b_i];

endmodule

// File: rtl/fft_bitrev_buffer_rtl.sv
// Ping-pong reorder buffer: natural-order samples in, bit-reversed stage-1 pairs out.
// Last sample accepted at edge t -> first pair valid at edge t+2; then one pair/cycle.
// in_ready low while the write bank is full; output register holds under out_ready=0.
// Optional build macro FFT_BITREV_SCALE_EN: halve Re/Im (arithmetic shift) on write.
module fft_bitrev_buffer_rtl
  import fft_package::*;
#(
  parameter int N_POINTS = FFT_N,
  localparam int LOG2N = $clog2(N_POINTS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  complex_t           in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output complex_t           out_first,
  output complex_t           out_second,
  output logic [LOG2N-2:0]   out_pair_idx,
  output logic               out_frame_start,
  output logic               out_frame_last
);

  localparam int               HALF      = N_POINTS / 2;
  localparam logic [LOG2N-1:0] WR_LAST   = LOG2N'(N_POINTS - 1);
  localparam logic [LOG2N-2:0] RD_LAST   = (LOG2N-1)'(HALF - 1);
  localparam logic [LOG2N-1:0] HALF_ADDR = LOG2N'(HALF);

  // ---------------------------------------------------------------- state
  rd_state_e         state_q, state_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [LOG2N-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LOG2N-2:0]  rd_cnt_q, rd_cnt_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              in_rdy_en_q;

  logic              out_valid_q, out_valid_d;
  complex_t          out_first_q, out_first_d;
  complex_t          out_second_q, out_second_d;
  logic [LOG2N-2:0]  out_idx_q, out_idx_d;
  logic              out_start_q, out_start_d;
  logic              out_last_q, out_last_d;

  // ---------------------------------------------------------------- datapath
  logic              wr_fire;
  logic              rd_load;
  complex_t          wr_data;
  complex_t          rd_data_a;
  complex_t          rd_data_b;
  logic [LOG2N-1:0]  rd_addr_a;
  logic [LOG2N-1:0]  rd_addr_b;

  // in_ready stays low during reset and for the reset-release cycle itself.
  assign in_ready = in_rdy_en_q & ~bank_full_q[wr_sel_q];
  assign wr_fire  = in_valid & in_ready;

`ifdef FFT_BITREV_SCALE_EN
  // Pre-scale by 1/2 against butterfly growth: floor shift keeps the sign.
  assign wr_data.re = word_t'($signed(in_data.re) >>> 1);
  assign wr_data.im = word_t'($signed(in_data.im) >>> 1);
`else
  assign wr_data = in_data;
`endif

  // Pair k reads x[bitrev(2k)] and its partner N/2 above; 2k has LSB 0,
  // so the reversed address has MSB 0 and the partner just sets that MSB.
  assign rd_addr_a = LOG2N'(bitrev(32'({rd_cnt_q, 1'b0}), LOG2N));
  assign rd_addr_b = rd_addr_a | HALF_ADDR;

  fft_pingpong_bank_rtl #(
    .N_POINTS (N_POINTS)
  ) u_bank (
    .clk         (clk),
    .wr_en_i     (wr_fire),
    .wr_bank_i   (wr_sel_q),
    .wr_addr_i   (wr_cnt_q),
    .wr_data_i   (wr_data),
    .rd_bank_i   (rd_sel_q),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .rd_data_a_o (rd_data_a),
    .rd_data_b_o (rd_data_b)
  );

  // The output register may take a new pair when it is empty or being consumed.
  assign rd_load = (state_q == R_DRAIN) && (!out_valid_q || out_ready);

  // Next-state for write counter, bank ownership, read FSM and output register.
  always_comb begin
    state_d      = state_q;
    wr_sel_d     = wr_sel_q;
    rd_sel_d     = rd_sel_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    bank_full_d  = bank_full_q;
    out_valid_d  = out_valid_q;
    out_first_d  = out_first_q;
    out_second_d = out_second_q;
    out_idx_d    = out_idx_q;
    out_start_d  = out_start_q;
    out_last_d   = out_last_q;

    // Writer: fill the current bank, hand it over on the last sample.
    if (wr_fire) begin
      if (wr_cnt_q == WR_LAST) begin
        bank_full_d[wr_sel_q] = 1'b1;
        wr_sel_d              = ~wr_sel_q;
        wr_cnt_d              = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    // Reader. The writer only ever touches a non-full bank and the reader
    // only releases a full one, so the two bank_full updates never collide.
    unique case (state_q)
      R_IDLE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
        end
        if (bank_full_q[rd_sel_q]) begin
          state_d  = R_DRAIN;
          rd_cnt_d = '0;
        end
      end

      R_DRAIN: begin
        if (rd_load) begin
          out_valid_d  = 1'b1;
          out_first_d  = rd_data_a;
          out_second_d = rd_data_b;
          out_idx_d    = rd_cnt_q;
          out_start_d  = (rd_cnt_q == '0);
          out_last_d   = (rd_cnt_q == RD_LAST);
          if (rd_cnt_q == RD_LAST) begin
            // Release is registered: the writer sees the bank free next cycle.
            bank_full_d[rd_sel_q] = 1'b0;
            rd_sel_d              = ~rd_sel_q;
            rd_cnt_d              = '0;
            state_d               = bank_full_q[~rd_sel_q] ? R_DRAIN : R_IDLE;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = R_IDLE;
      end
    endcase
  end

  // Control and output registers; bank contents live in the bank module.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= R_IDLE;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      bank_full_q  <= '0;
      in_rdy_en_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_first_q  <= '0;
      out_second_q <= '0;
      out_idx_q    <= '0;
      out_start_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      bank_full_q  <= bank_full_d;
      in_rdy_en_q  <= 1'b1;
      out_valid_q  <= out_valid_d;
      out_first_q  <= out_first_d;
      out_second_q <= out_second_d;
      out_idx_q    <= out_idx_d;
      out_start_q  <= out_start_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_first       = out_first_q;
  assign out_second      = out_second_q;
  assign out_pair_idx    = out_idx_q;
  assign out_frame_start = out_start_q;
  assign out_frame_last  = out_last_q;

endmodule

// File: tb/tb_fft_bitrev_buffer_rtl.sv
// Bench for the bit-reverse ping-pong buffer: scoreboard plus table and corner sequences.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// Exercises stalls, both-banks-full backpressure and asynchronous reset mid-frame.
module tb_fft_bitrev_buffer_rtl;
  import fft_package::*;

  localparam int N = 16;
  localparam int H = 8;

  logic      clk = 1'b0;
  logic      reset;
  logic      in_valid;
  logic      in_ready;
  complex_t  in_data;
  logic      out_valid;
  logic      out_ready;
  complex_t  out_first;
  complex_t  out_second;
  pair_idx_t out_pair_idx;
  logic      out_frame_start;
  logic      out_frame_last;

  always #5 clk = ~clk;

  fft_bitrev_buffer_rtl dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_first       (out_first),
    .out_second      (out_second),
    .out_pair_idx    (out_pair_idx),
    .out_frame_start (out_frame_start),
    .out_frame_last  (out_frame_last)
  );

  typedef struct {
    pair_idx_t k;
    complex_t  first;
    complex_t  second;
    logic      start;
    logic      last;
  } pair_t;

  typedef struct {
    int   k;
    int   f;
    int   s;
    logic start;
    logic last;
  } vec_t;

  int    checks = 0;
  int    passed = 0;
  int    cyc    = 0;
  pair_t sb_q[$];
  pair_t cap_q[$];
  int    pop_cyc[$];
  pair_t mon_e;

  complex_t mdl_buf[N];
  int       mdl_cnt = 0;
  int       first_tab[H] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic complex_t mk(input int v);
    complex_t c;
    c.re = word_t'(v);
    c.im = word_t'(-v);
    return c;
  endfunction

  // Expected stored value: floor(v/2) written as (v - lsb)/2 when pre-scaling is built in.
  function automatic complex_t scl(input complex_t c);
    complex_t r;
`ifdef FFT_BITREV_SCALE_EN
    int vr, vi;
    vr = int'(c.re);
    vi = int'(c.im);
    r.re = word_t'((vr - (vr & 1)) / 2);
    r.im = word_t'((vi - (vi & 1)) / 2);
`else
    r = c;
`endif
    return r;
  endfunction

  task automatic mdl_push(input complex_t d);
    pair_t p;
    mdl_buf[mdl_cnt] = scl(d);
    mdl_cnt++;
    if (mdl_cnt == N) begin
      for (int k = 0; k < H; k++) begin
        p.k      = pair_idx_t'(k);
        p.first  = mdl_buf[first_tab[k]];
        p.second = mdl_buf[first_tab[k] + H];
        p.start  = (k == 0);
        p.last   = (k == H - 1);
        sb_q.push_back(p);
      end
      mdl_cnt = 0;
    end
  endtask

  // Output monitor: every accepted pair is popped against the scoreboard.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      cap_q.push_back('{k: out_pair_idx, first: out_first, second: out_second,
                        start: out_frame_start, last: out_frame_last});
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pair: got k=%0d first=%h, expected no pair", out_pair_idx, out_first);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pair_data", {out_first, out_second}, {mon_e.first, mon_e.second});
        chk("pair_meta", 64'({out_pair_idx, out_frame_start, out_frame_last}),
            64'({mon_e.k, mon_e.start, mon_e.last}));
      end
    end
  end

  task automatic drive_cycle(input logic v, input complex_t d, output logic acc);
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    #1;
  endtask

  // Send one frame x[i] = base+i; 'special' replaces x0/x8 with the scaling corner values.
  task automatic send_frame(input int base, input logic special, output int drops);
    int       i;
    logic     acc;
    complex_t d;
    i     = 0;
    drops = 0;
    while (i < N && drops < 200) begin
      d = mk(base + i);
      if (special && i == 0) begin d.re = -16'sd3; d.im = 16'sh7FFF; end
      if (special && i == 8) begin d.re = 16'sd5;  d.im = -16'sd1;   end
      drive_cycle(1'b1, d, acc);
      if (acc) begin mdl_push(d); i++; end
      else drops++;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t     tbl[5];
    int       drops, lat, n, base_pop, idx, acc_cnt;
    logic     acc, found;
    complex_t e0f, e0s;

    tbl[0] = '{k: 0, f: 0, s: 8,  start: 1'b1, last: 1'b0};
    tbl[1] = '{k: 1, f: 4, s: 12, start: 1'b0, last: 1'b0};
    tbl[2] = '{k: 2, f: 2, s: 10, start: 1'b0, last: 1'b0};
    tbl[3] = '{k: 3, f: 6, s: 14, start: 1'b0, last: 1'b0};
    tbl[4] = '{k: 7, f: 7, s: 15, start: 1'b0, last: 1'b1};

    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    idle(2);
    chk("reset_outputs", 64'({out_valid, out_first, out_pair_idx, out_frame_start, out_frame_last}), 64'(0));
    chk("reset_second", 64'(out_second), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    reset = 1'b1;
    #1;
    chk("in_ready_before_edge", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    chk("in_ready_after_edge", 64'(in_ready), 64'(1));

    // Frame 0: latency and the fixed pair table.
    out_ready = 1'b1;
    cap_q.delete();
    send_frame(0, 1'b0, drops);
    lat = 0;
    while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    chk("first_out_latency", 64'(lat), 64'(2));
    idle(12);
    chk("frame0_pair_count", 64'(cap_q.size()), 64'(H));
    for (int j = 0; j < 5; j++) begin
      if (tbl[j].k < cap_q.size()) begin
        chk($sformatf("table_k%0d_data", tbl[j].k),
            {cap_q[tbl[j].k].first, cap_q[tbl[j].k].second},
            {scl(mk(tbl[j].f)), scl(mk(tbl[j].s))});
        chk($sformatf("table_k%0d_flags", tbl[j].k),
            64'({cap_q[tbl[j].k].k, cap_q[tbl[j].k].start, cap_q[tbl[j].k].last}),
            64'({pair_idx_t'(tbl[j].k), tbl[j].start, tbl[j].last}));
      end
    end

    // Three frames streamed without pauses.
    base_pop = cap_q.size();
    n = 0;
    for (int f = 0; f < 3; f++) begin
      send_frame(32 + 16 * f, 1'b0, drops);
      n += drops;
    end
    idle(20);
    chk("cont_in_ready_drops", 64'(n), 64'(0));
    chk("cont_pair_count", 64'(cap_q.size() - base_pop), 64'(3 * H));

    // Stall at k3 for five cycles.
    send_frame(100, 1'b0, drops);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (out_valid && out_pair_idx == 3) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("stall_k3_seen", 64'(found), 64'(1));
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_hold_data", {out_first, out_second}, {scl(mk(106)), scl(mk(114))});
      chk("stall_hold_meta", 64'({out_valid, out_pair_idx}), 64'({1'b1, 3'd3}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("resume_k4", {out_first, out_second}, {scl(mk(101)), scl(mk(109))});
    idle(10);

    // Both banks full under permanent backpressure.
    out_ready = 1'b0;
    idx = 0;
    acc_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      drive_cycle(1'b1, mk(200 + idx), acc);
      if (acc) begin mdl_push(mk(200 + idx)); idx++; acc_cnt++; end
    end
    in_valid = 1'b0;
    idle(3);
    chk("full_accepted", 64'(acc_cnt), 64'(2 * N));
    chk("full_in_ready_low", 64'(in_ready), 64'(0));
    base_pop = pop_cyc.size();
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 30) begin @(posedge clk); #1; n++; end
    chk("full_release_cycles", 64'(n), 64'(H - 1));
    idle(15);
    chk("full_drained_pairs", 64'(pop_cyc.size() - base_pop), 64'(2 * H));
    if (pop_cyc.size() >= base_pop + 9)
      chk("frame_boundary_gap", 64'(pop_cyc[base_pop + 8] - pop_cyc[base_pop + 7]), 64'(1));

    // Asynchronous reset mid-drain (k3) with the other bank mid-fill.
    idx = 0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      drive_cycle(1'b1, mk(300 + idx), acc);
      if (acc) begin mdl_push(mk(300 + idx)); idx++; end
      if (out_valid && out_pair_idx == 3) found = 1'b1;
    end
    chk("reset_k3_seen", 64'(found), 64'(1));
    chk("reset_midfill", 64'(idx > N), 64'(1));
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({out_valid, out_first, out_pair_idx, out_frame_start, out_frame_last}), 64'(0));
    chk("async_reset_in_ready", 64'(in_ready), 64'(0));
    sb_q.delete();
    mdl_cnt = 0;
    idle(2);
    cap_q.delete();
    reset = 1'b1;
    idle(1);
    send_frame(0, 1'b0, drops);
    idle(14);
    chk("post_reset_pairs", 64'(cap_q.size()), 64'(H));
    if (cap_q.size() > 0)
      chk("post_reset_k0", {cap_q[0].first, cap_q[0].second}, {scl(mk(0)), scl(mk(8))});

    // Scaling corner values on x0/x8.
    cap_q.delete();
    send_frame(400, 1'b1, drops);
    idle(14);
`ifdef FFT_BITREV_SCALE_EN
    e0f.re = -16'sd2; e0f.im = 16'sh3FFF; e0s.re = 16'sd2; e0s.im = -16'sd1;
`else
    e0f.re = -16'sd3; e0f.im = 16'sh7FFF; e0s.re = 16'sd5; e0s.im = -16'sd1;
`endif
    if (cap_q.size() > 0)
      chk("scale_k0", {cap_q[0].first, cap_q[0].second}, {e0f, e0s});
    else
      chk("scale_k0_present", 64'(cap_q.size()), 64'(H));

    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
